// File: rtl/alu_pkg.sv
// Shared opcode and FSM-state definitions for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_SLL  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SRA  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_MULU = 4'd8;
    localparam logic [3:0] ALU_DIVU = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: shift-add unsigned multiply and, with ALU_DIV_EN defined,
// restoring unsigned divide. Exposes the post-step values so the caller can capture the last step.
module alu_iter_unit #(
    parameter int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
`ifdef ALU_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] lo_nxt,
    output logic [WIDTH-1:0] hi_nxt
);

    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] opd_q, hi_q, lo_q;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;

    // {hi,lo} starts as {0, multiplier}; each step adds the multiplicand if lo[0] and shifts right.
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

`ifdef ALU_DIV_EN
    logic             div_q;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             ge;

    // hi holds the partial remainder, lo the dividend shifting out / quotient shifting in.
    // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
    always_comb begin
        rem_sh  = {hi_q, lo_q[WIDTH-1]};
        ge      = rem_sh >= {1'b0, opd_q};
        rem_sub = rem_sh[WIDTH-1:0] - opd_q;
        hi_nxt  = div_q ? (ge ? rem_sub : rem_sh[WIDTH-1:0]) : mul_hi;
        lo_nxt  = div_q ? {lo_q[WIDTH-2:0], ge} : mul_lo;
    end
`else
    always_comb begin
        hi_nxt = mul_hi;
        lo_nxt = mul_lo;
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            opd_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
`ifdef ALU_DIV_EN
            div_q <= 1'b0;
`endif
        end else if (load) begin
            cnt_q <= CNT_W'(WIDTH);
            hi_q  <= '0;
`ifdef ALU_DIV_EN
            div_q <= is_div;
            opd_q <= is_div ? b : a;
            lo_q  <= is_div ? a : b;
`else
            opd_q <= a;
            lo_q  <= b;
`endif
        end else if (step) begin
            cnt_q <= cnt_q - CNT_W'(1);
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/alu_seq.sv
// WIDTH-bit ALU with registered outputs and start/busy/done handshake.
// Define ALU_DIV_EN to enable the iterative unsigned divide on opcode 9.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int SHAMT_W = $clog2(WIDTH),
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d;
    logic             zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] res_1c, sum, diff;
    logic             ovf_1c, is_iter, load, step;
    logic [SHAMT_W-1:0] shamt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] lo_nxt, hi_nxt;

    always_comb begin
        shamt  = in2[SHAMT_W-1:0];
        sum    = in1 + in2;
        diff   = in1 - in2;
        res_1c = '0;
        ovf_1c = 1'b0;
        case (control)
            ALU_AND: res_1c = in1 & in2;
            ALU_OR:  res_1c = in1 | in2;
            ALU_ADD: begin
                res_1c = sum;
                ovf_1c = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
            end
            ALU_SUB: begin
                res_1c = diff;
                ovf_1c = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
            end
            ALU_SLL: res_1c = in1 << shamt;
            ALU_SRL: res_1c = in1 >> shamt;
            ALU_SRA: res_1c = WIDTH'($signed(in1) >>> shamt);
            ALU_SLT: res_1c = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
            default: res_1c = '0;
        endcase
`ifdef ALU_DIV_EN
        is_iter = (control == ALU_MULU) || (control == ALU_DIVU);
`else
        is_iter = (control == ALU_MULU);
`endif
    end

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clock  (clock),
        .reset  (reset),
        .load   (load),
        .step   (step),
`ifdef ALU_DIV_EN
        .is_div (control == ALU_DIVU),
`endif
        .a      (in1),
        .b      (in2),
        .cnt    (cnt),
        .lo_nxt (lo_nxt),
        .hi_nxt (hi_nxt)
    );

    // FIN carries the done pulse with busy low, so it accepts a new start just like IDLE.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        hi_d    = hi_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                if (start) begin
                    if (is_iter) begin
                        load    = 1'b1;
                        busy_d  = 1'b1;
                        state_d = S_ITER;
                    end else begin
                        done_d = 1'b1;
                        res_d  = res_1c;
                        hi_d   = '0;
                        ovf_d  = ovf_1c;
                    end
                end
            end
            S_ITER: begin
                step = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    res_d   = lo_nxt;
                    hi_d    = hi_nxt;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        zero_d = done_d ? (res_d == '0) : zero_q;
        neg_d  = done_d ? res_d[WIDTH-1] : neg_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign result    = res_q;
    assign result_hi = hi_q;
    assign zero      = zero_q;
    assign negative  = neg_q;
    assign overflow  = ovf_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=16; ALU_DIV_EN selects the divide vectors.
module tb_alu_seq;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   control = 4'd0;
    logic [W-1:0] in1 = '0, in2 = '0;
    logic [W-1:0] result, result_hi;
    logic         zero, negative, overflow, busy, done;

    int checks = 0;
    int failures = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .control   (control),
        .in1       (in1),
        .in2       (in2),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        control = op; in1 = a; in2 = b; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // flags are {zero, negative, overflow}
    task automatic run1(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic [2:0] ef);
        issue(op, a, b);
        check({tag, "_done"}, {31'b0, done}, 1);
        check({tag, "_busy"}, {31'b0, busy}, 0);
        check({tag, "_res"}, result, er);
        check({tag, "_hi"}, result_hi, 0);
        check({tag, "_flg"}, {29'b0, zero, negative, overflow}, ef);
    endtask

    task automatic runm(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] elo, input logic [W-1:0] ehi,
                        input logic [2:0] ef, input bit poke);
        int n = 0;
        int bcnt = 0;
        issue(op, a, b);
        while (!done && n < 40) begin
            if (busy) bcnt++;
            if (poke && n == 5) begin
                control = 4'd2; in1 = 16'h0001; in2 = 16'h0001; start = 1'b1;
            end
            if (n == 6) start = 1'b0;
            @(posedge clock);
            #1;
            n++;
        end
        check({tag, "_done"}, {31'b0, done}, 1);
        check({tag, "_lat"}, n, 16);
        check({tag, "_busycyc"}, bcnt, 16);
        check({tag, "_busy_at_done"}, {31'b0, busy}, 0);
        check({tag, "_lo"}, result, elo);
        check({tag, "_hi"}, result_hi, ehi);
        check({tag, "_flg"}, {29'b0, zero, negative, overflow}, ef);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_res", result, 0);
        check("rst_hi", result_hi, 0);
        check("rst_ctl", {27'b0, zero, negative, overflow, busy, done}, 0);
        @(negedge clock);
        reset = 1'b0;

        run1("add_ovf", 4'd2, 16'h7FFF, 16'h0001, 16'h8000, 3'b011);
        run1("sub_wrap", 4'd3, 16'h0000, 16'h0001, 16'hFFFF, 3'b010);
        run1("sub_ovf", 4'd3, 16'h8000, 16'h0001, 16'h7FFF, 3'b001);
        run1("add_zero", 4'd2, 16'hFFFF, 16'h0001, 16'h0000, 3'b100);
        run1("slt", 4'd7, 16'h0001, 16'hFFFF, 16'h0000, 3'b100);
        run1("slt_t", 4'd7, 16'hFFFF, 16'h0001, 16'h0001, 3'b000);
        run1("sra", 4'd6, 16'h8000, 16'h000F, 16'hFFFF, 3'b010);
        run1("srl", 4'd5, 16'h8000, 16'h000F, 16'h0001, 3'b000);
        run1("sll_mask", 4'd4, 16'h0001, 16'h0011, 16'h0002, 3'b000);
        run1("and", 4'd0, 16'hF0F0, 16'h0FF0, 16'h00F0, 3'b000);
        run1("or", 4'd1, 16'hF0F0, 16'h0FF0, 16'hFFF0, 3'b010);
        run1("rsvd", 4'd12, 16'h1234, 16'h5678, 16'h0000, 3'b100);

        // idle cycle: done drops, outputs hold
        @(posedge clock);
        #1;
        check("idle_done", {31'b0, done}, 0);
        check("hold_res", result, 0);
        check("hold_zero", {31'b0, zero}, 1);

        runm("mulu_max", 4'd8, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 3'b000, 1'b1);
        runm("mulu_sm", 4'd8, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 3'b000, 1'b0);
        run1("add_after_mul", 4'd2, 16'h0003, 16'h0004, 16'h0007, 3'b000);

`ifdef ALU_DIV_EN
        runm("divu", 4'd9, 16'd100, 16'd7, 16'd14, 16'd2, 3'b000, 1'b0);
        runm("divu_z", 4'd9, 16'd5, 16'd0, 16'hFFFF, 16'h0005, 3'b010, 1'b0);
`else
        run1("op9_rsvd", 4'd9, 16'd100, 16'd7, 16'h0000, 3'b100);
`endif

        // reset in cycle 5 of a multiply aborts it with no done pulse
        issue(4'd8, 16'h00FF, 16'h00FF);
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_res", result, 0);
        check("abort_hi", result_hi, 0);
        check("abort_ctl", {28'b0, zero, negative, overflow, done}, 0);
        @(negedge clock);
        reset = 1'b0;
        begin
            int seen = 0;
            repeat (20) begin
                @(posedge clock);
                #1;
                if (done || busy) seen++;
            end
            check("abort_no_done", seen, 0);
        end
        run1("add_post_rst", 4'd2, 16'h0001, 16'h0001, 16'h0002, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
